load_store_unit: RTL and testbench

Multicycle load/store sequencer between the processing unit's datapath and the 64-bit data memory. It takes a load or store request (address from ALUOut, store data from register B, funct3 from the instruction), then performs the doubleword read, lane extraction with sign/zero extension, or read-modify-write merge. It returns the extended load value to the MemDataReg write-back path with a start/done handshake, so the control FSM only waits on `Done`.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signal bundle for load_store_unit
//
// Purpose: groups the datapath request side and the 64-bit data memory side of the
// load/store sequencer into one interface.
// Modports:
//   master - datapath/memory environment: drives Start, IsStore, Funct3, Addr,
//            StoreData, MemRData; observes the sequencer outputs.
//   slave  - load_store_unit: receives the request and MemRData; drives MemAddr,
//            MemWrite, MemWData, Busy, Done, LoadData, Err.

interface load_store_unit_if;
  logic        Start;
  logic        IsStore;
  logic [2:0]  Funct3;
  logic [63:0] Addr;
  logic [63:0] StoreData;
  logic [63:0] MemAddr;
  logic        MemWrite;
  logic [63:0] MemWData;
  logic [63:0] MemRData;
  logic        Busy;
  logic        Done;
  logic [63:0] LoadData;
  logic        Err;

  modport master (
    output Start, IsStore, Funct3, Addr, StoreData, MemRData,
    input  MemAddr, MemWrite, MemWData, Busy, Done, LoadData, Err
  );

  modport slave (
    input  Start, IsStore, Funct3, Addr, StoreData, MemRData,
    output MemAddr, MemWrite, MemWData, Busy, Done, LoadData, Err
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle load/store sequencer for a 64-bit data memory
//
// Purpose: accepts one load or store request at a time, performs the doubleword
// read, lane extraction with sign/zero extension, or read-modify-write merge, and
// reports completion with a one-cycle Done pulse.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   Reset    - asynchronous active-high reset
//   lsu      - load_store_unit_if.slave: Start/IsStore/Funct3/Addr/StoreData request,
//              MemAddr/MemWrite/MemWData/MemRData memory side, Busy/Done/LoadData/Err status
// Parameter:
//   MEM_LAT  - rising edges from entering RD to the edge that samples MemRData (1..15)

module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               Reset,
  load_store_unit_if.slave   lsu
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request fields latched at acceptance. Only the in-doubleword byte offset and
  // the low word of the store data are needed after the accepting edge: MemAddr
  // is set on that edge and SD writes StoreData directly.
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  off_q, off_d;
  logic [31:0] sdata_q, sdata_d;

  logic [63:0] mem_addr_d;
  logic        mem_write_d;
  logic [63:0] mem_wdata_d;
  logic [63:0] load_data_d;
  logic        err_d;

  logic        illegal_req;
  logic [63:0] lane_shift;
  logic [63:0] load_ext;
  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] data_shift;
  logic [63:0] merged;

  // Illegal: unknown funct3 for the direction, or not naturally aligned.
  always_comb begin
    illegal_req = lsu.IsStore ? lsu.Funct3[2] : (lsu.Funct3 == 3'b111);
    case (lsu.Funct3[1:0])
      2'b01:   if (lsu.Addr[0])      illegal_req = 1'b1;
      2'b10:   if (|lsu.Addr[1:0])   illegal_req = 1'b1;
      2'b11:   if (|lsu.Addr[2:0])   illegal_req = 1'b1;
      default: ;
    endcase
  end

  // The doubleword is consumed on the sampling edge itself: the extended load
  // value and the merged write data are both registered from MemRData there, so
  // LoadData / MemWData act as the captured-doubleword register.
  always_comb begin
    lane_shift = lsu.MemRData >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{56{lane_shift[7]}},  lane_shift[7:0]};
      3'b001:  load_ext = {{48{lane_shift[15]}}, lane_shift[15:0]};
      3'b010:  load_ext = {{32{lane_shift[31]}}, lane_shift[31:0]};
      3'b100:  load_ext = {56'd0, lane_shift[7:0]};
      3'b101:  load_ext = {48'd0, lane_shift[15:0]};
      3'b110:  load_ext = {32'd0, lane_shift[31:0]};
      default: load_ext = lane_shift;
    endcase
  end

  // Partial-store merge: byte lanes off..off+n-1 come from the store data,
  // the rest from the doubleword just read.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   byte_mask = 8'h01 << off_q;
      2'b01:   byte_mask = 8'h03 << off_q;
      default: byte_mask = 8'h0F << off_q;
    endcase
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
    data_shift = {32'd0, sdata_q} << {off_q, 3'b000};
    merged     = (lsu.MemRData & ~bit_mask) | (data_shift & bit_mask);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    sdata_d     = sdata_q;
    mem_addr_d  = lsu.MemAddr;
    mem_write_d = 1'b0;
    mem_wdata_d = lsu.MemWData;
    load_data_d = lsu.LoadData;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (lsu.Start) begin
          is_store_d = lsu.IsStore;
          funct3_d   = lsu.Funct3;
          off_d      = lsu.Addr[2:0];
          sdata_d    = lsu.StoreData[31:0];
          if (illegal_req) begin
            // No memory access at all: MemAddr is left where it was.
            state_d = DONE;
            err_d   = 1'b1;
          end else if (lsu.IsStore && lsu.Funct3[1:0] == 2'b11) begin
            // SD needs no read.
            state_d     = WR;
            mem_addr_d  = {lsu.Addr[63:3], 3'b000};
            mem_write_d = 1'b1;
            mem_wdata_d = lsu.StoreData;
          end else begin
            state_d    = RD;
            cnt_d      = 4'd0;
            mem_addr_d = {lsu.Addr[63:3], 3'b000};
          end
        end
      end

      RD: begin
        if (cnt_q == LAT_LAST) begin
          if (is_store_q) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d     = DONE;
            load_data_d = load_ext;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WR: begin
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 3'd0;
      sdata_q      <= 32'd0;
      lsu.MemAddr  <= 64'd0;
      lsu.MemWrite <= 1'b0;
      lsu.MemWData <= 64'd0;
      lsu.Busy     <= 1'b0;
      lsu.Done     <= 1'b0;
      lsu.LoadData <= 64'd0;
      lsu.Err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      sdata_q      <= sdata_d;
      lsu.MemAddr  <= mem_addr_d;
      lsu.MemWrite <= mem_write_d;
      lsu.MemWData <= mem_wdata_d;
      lsu.Busy     <= (state_d != IDLE);
      lsu.Done     <= (state_d == DONE);
      lsu.LoadData <= load_data_d;
      lsu.Err      <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  load_store_unit_if lsu ();

  load_store_unit #(.MEM_LAT(LAT)) dut (
    .clk   (clk),
    .Reset (Reset),
    .lsu   (lsu)
  );

  // Memory seen by the DUT (32 doublewords, byte addresses 0x00..0xFF) and the
  // reference copy updated only by the model.
  logic [63:0] mem     [0:31];
  logic [63:0] ref_mem [0:31];
  assign lsu.MemRData = mem[lsu.MemAddr[7:3]];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_count;
  logic [63:0] wr_addr;
  logic [63:0] wr_data;
  logic [63:0] exp_ld;

  // One clock cycle, starting and ending just after a falling edge. Memory
  // writes are committed just before the rising edge that ends the WR cycle.
  task automatic tick();
    #4;
    if (lsu.MemWrite === 1'b1) begin
      wr_count++;
      wr_addr = lsu.MemAddr;
      wr_data = lsu.MemWData;
      mem[lsu.MemAddr[7:3]] = lsu.MemWData;
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] dw, input int off,
                                             input logic [2:0] f3);
    int          n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(dw[8*(off+i) +: 8]) << (8*i));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  function automatic logic model_legal(input logic st, input logic [2:0] f3,
                                       input logic [63:0] a);
    int n = 1 << f3[1:0];
    if (st && f3[2]) return 1'b0;
    if (!st && f3 == 3'b111) return 1'b0;
    return (a % n) == 0;
  endfunction

  // Issue one request; lat is the number of cycles after the accepting edge
  // until Done is seen (-1 on timeout).
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, output int lat, output logic err,
                       output logic busy0, output logic mw0);
    wr_count      = 0;
    lat           = -1;
    err           = 1'b0;
    lsu.Start     = 1'b1;
    lsu.IsStore   = st;
    lsu.Funct3    = f3;
    lsu.Addr      = a;
    lsu.StoreData = sd;
    tick();
    lsu.Start = 1'b0;
    busy0     = lsu.Busy;
    mw0       = lsu.MemWrite;
    for (int d = 0; d < 40; d++) begin
      if (lsu.Done === 1'b1) begin
        lat = d;
        err = lsu.Err;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    Reset = 1'b1;
    lsu.Start = 1'b0; lsu.IsStore = 1'b0; lsu.Funct3 = 3'd0;
    lsu.Addr = 64'd0; lsu.StoreData = 64'd0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    wr_count = 0;
    for (int c = 0; c < 3; c++) begin
      outs = lsu.MemAddr | lsu.MemWData | lsu.LoadData |
             64'({lsu.MemWrite, lsu.Busy, lsu.Done, lsu.Err});
      n_checks++;
      if (outs !== 64'd0) $display("FAIL reset_outputs cycle %0d: got %h required 0", c, outs);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (wr_count !== 0) $display("FAIL reset_no_write: got %0d writes required 0", wr_count);
    else n_pass++;
  endtask

  task automatic test_directed_loads();
    int lat; logic err, b0, mw0;
    logic [63:0] exp [3] = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000000088, 64'h0000000088776655};
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b110};
    logic [63:0] adr [3] = '{64'h17, 64'h17, 64'h14};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, f3s[i], adr[i], 64'd0, lat, err, b0, mw0);
      exp_ld = exp[i];
      n_checks++;
      if (lsu.LoadData !== exp[i]) $display("FAIL load%0d_data: got %h required %h", i, lsu.LoadData, exp[i]);
      else n_pass++;
      n_checks++;
      if (lat !== LAT || err !== 1'b0 || b0 !== 1'b1)
        $display("FAIL load%0d_timing: got lat %0d err %b busy %b required lat %0d err 0 busy 1", i, lat, err, b0, LAT);
      else n_pass++;
    end
  endtask

  task automatic test_partial_store();
    int lat; logic err, b0, mw0;
    do_op(1'b1, 3'b001, 64'h12, 64'h000000000000ABCD, lat, err, b0, mw0);
    ref_mem[2] = 64'h88776655ABCD2211;
    n_checks++;
    if (wr_count !== 1 || wr_addr !== 64'h10 || wr_data !== 64'h88776655ABCD2211)
      $display("FAIL sh_write: got %0d writes addr %h data %h required 1 writes addr 10 data 88776655abcd2211", wr_count, wr_addr, wr_data);
    else n_pass++;
    n_checks++;
    if (lat !== LAT + 1 || err !== 1'b0) $display("FAIL sh_timing: got lat %0d err %b required lat %0d err 0", lat, err, LAT + 1);
    else n_pass++;
    n_checks++;
    if (lsu.LoadData !== exp_ld) $display("FAIL sh_loaddata_held: got %h required %h", lsu.LoadData, exp_ld);
    else n_pass++;
  endtask

  task automatic test_sd();
    int lat; logic err, b0, mw0;
    do_op(1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF, lat, err, b0, mw0);
    ref_mem[4] = 64'h0123456789ABCDEF;
    n_checks++;
    if (mw0 !== 1'b1 || wr_count !== 1 || wr_addr !== 64'h20 || wr_data !== 64'h0123456789ABCDEF)
      $display("FAIL sd_write: got first-cycle write %b count %0d addr %h data %h required 1 1 20 0123456789abcdef", mw0, wr_count, wr_addr, wr_data);
    else n_pass++;
    n_checks++;
    if (lat !== 1 || err !== 1'b0) $display("FAIL sd_timing: got lat %0d err %b required lat 1 err 0", lat, err);
    else n_pass++;
  endtask

  task automatic test_errors();
    int lat; logic err, b0, mw0;
    logic        sts [2] = '{1'b0, 1'b1};
    logic [2:0]  f3s [2] = '{3'b010, 3'b100};
    logic [63:0] adr [2] = '{64'h16, 64'h10};
    for (int i = 0; i < 2; i++) begin
      do_op(sts[i], f3s[i], adr[i], 64'hFFFF_FFFF_FFFF_FFFF, lat, err, b0, mw0);
      n_checks++;
      if (lat !== 0 || err !== 1'b1 || wr_count !== 0)
        $display("FAIL err%0d: got lat %0d err %b writes %0d required lat 0 err 1 writes 0", i, lat, err, wr_count);
      else n_pass++;
      n_checks++;
      if (lsu.LoadData !== exp_ld || lsu.Err !== 1'b0)
        $display("FAIL err%0d_after: got LoadData %h Err %b required %h 0", i, lsu.LoadData, lsu.Err, exp_ld);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    logic seen;
    wr_count = 0;
    seen = 1'b0;
    lsu.Start = 1'b1; lsu.IsStore = 1'b1; lsu.Funct3 = 3'b000;
    lsu.Addr = 64'h31; lsu.StoreData = 64'h5A;
    tick();
    // Second request while busy: SD to 0x40 must be dropped.
    lsu.Funct3 = 3'b011; lsu.Addr = 64'h40; lsu.StoreData = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    lsu.Start = 1'b0;
    for (int d = 0; d < 40; d++) begin
      if (lsu.Done === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    for (int c = 0; c < 4; c++) tick();
    ref_mem[6][15:8] = 8'h5A;
    n_checks++;
    if (!seen || wr_count !== 1 || wr_addr !== 64'h30 || wr_data !== ref_mem[6])
      $display("FAIL busy_ignore_write: got done %b writes %0d addr %h data %h required 1 1 30 %h", seen, wr_count, wr_addr, wr_data, ref_mem[6]);
    else n_pass++;
    n_checks++;
    if (mem[8] !== ref_mem[8] || lsu.Busy !== 1'b0)
      $display("FAIL busy_ignore_mem: got mem40 %h busy %b required %h 0", mem[8], lsu.Busy, ref_mem[8]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic err, b0, mw0;
    logic [63:0] outs;
    // SB with reset during RD.
    wr_count = 0;
    lsu.Start = 1'b1; lsu.IsStore = 1'b1; lsu.Funct3 = 3'b000;
    lsu.Addr = 64'h33; lsu.StoreData = 64'h77;
    tick();
    lsu.Start = 1'b0;
    Reset = 1'b1;
    #1;
    outs = lsu.MemAddr | lsu.MemWData | lsu.LoadData |
           64'({lsu.MemWrite, lsu.Busy, lsu.Done, lsu.Err});
    n_checks++;
    if (outs !== 64'd0) $display("FAIL reset_rd_outputs: got %h required 0", outs);
    else n_pass++;
    @(negedge clk);
    Reset = 1'b0;
    exp_ld = 64'd0;
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (wr_count !== 0 || mem[6] !== ref_mem[6]) $display("FAIL reset_rd_nowrite: got %0d writes mem30 %h required 0 %h", wr_count, mem[6], ref_mem[6]);
    else n_pass++;
    // SD with reset inside the WR cycle.
    lsu.Start = 1'b1; lsu.Funct3 = 3'b011; lsu.Addr = 64'h28; lsu.StoreData = 64'h1111_2222_3333_4444;
    tick();
    lsu.Start = 1'b0;
    mw0 = lsu.MemWrite;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (mw0 !== 1'b1 || lsu.MemWrite !== 1'b0 || lsu.MemWData !== 64'd0)
      $display("FAIL reset_wr_drop: got before %b after %b wdata %h required 1 0 0", mw0, lsu.MemWrite, lsu.MemWData);
    else n_pass++;
    @(negedge clk);
    Reset = 1'b0;
    tick();
    n_checks++;
    if (mem[5] !== ref_mem[5]) $display("FAIL reset_wr_mem: got %h required %h", mem[5], ref_mem[5]);
    else n_pass++;
    // Normal LD afterwards.
    do_op(1'b0, 3'b011, 64'h30, 64'd0, lat, err, b0, mw0);
    exp_ld = ref_mem[6];
    n_checks++;
    if (lat !== LAT || err !== 1'b0 || lsu.LoadData !== exp_ld)
      $display("FAIL ld_after_reset: got lat %0d err %b data %h required %0d 0 %h", lat, err, lsu.LoadData, LAT, exp_ld);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, exp_lat, off, n; logic err, b0, mw0, st, legal;
    logic [2:0] f3; logic [63:0] a, sd; int idx;
    for (int t = 0; t < 80; t++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = st ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      n   = 1 << f3[1:0];
      idx = $urandom_range(0, 31);
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = off - (off % n);
      a   = 64'(idx * 8 + off);
      sd  = {$urandom, $urandom};
      legal = model_legal(st, f3, a);
      if (!legal) exp_lat = 0;
      else if (st && f3 == 3'b011) exp_lat = 1;
      else if (st) exp_lat = LAT + 1;
      else exp_lat = LAT;
      if (legal && st) for (int i = 0; i < n; i++) ref_mem[idx][8*(off+i) +: 8] = sd[8*i +: 8];
      if (legal && !st) exp_ld = model_load(ref_mem[idx], off, f3);
      do_op(st, f3, a, sd, lat, err, b0, mw0);
      n_checks++;
      if (lat !== exp_lat || err !== !legal)
        $display("FAIL rand%0d_timing st %b f3 %0d addr %h: got lat %0d err %b required %0d %b", t, st, f3, a, lat, err, exp_lat, !legal);
      else n_pass++;
      n_checks++;
      if (lsu.LoadData !== exp_ld)
        $display("FAIL rand%0d_loaddata st %b f3 %0d addr %h: got %h required %h", t, st, f3, a, lsu.LoadData, exp_ld);
      else n_pass++;
      n_checks++;
      if (legal && st) begin
        if (wr_count !== 1 || wr_addr !== 64'(idx * 8) || wr_data !== ref_mem[idx])
          $display("FAIL rand%0d_write: got %0d writes addr %h data %h required 1 %h %h", t, wr_count, wr_addr, wr_data, 64'(idx * 8), ref_mem[idx]);
        else n_pass++;
      end else begin
        if (wr_count !== 0) $display("FAIL rand%0d_nowrite: got %0d writes required 0", t, wr_count);
        else n_pass++;
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (mem[i] !== ref_mem[i]) $display("FAIL final_mem[%0d]: got %h required %h", i, mem[i], ref_mem[i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[2]     = 64'h8877665544332211;
    ref_mem[2] = 64'h8877665544332211;
    exp_ld     = 64'd0;
    test_reset();
    test_directed_loads();
    test_partial_store();
    test_sd();
    test_errors();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
